// File: rtl/onn_phase_sequencer_if.sv
// Bundles the control, strobe and status signals between the ONN phase
// sequencer and the host/oscillator array it drives. The master modport is
// the sequencer side. The slave modport is the host plus phase-register side.
interface onn_phase_sequencer_if #(
    parameter int N_OSC = 15
);
    logic             start;
    logic             abort;
    logic [N_OSC-1:0] state_changed;
    logic             re;
    logic             drop;
    logic             state_cheak;
    logic             busy;
    logic             done;
    logic             converged;
    logic [7:0]       iter_count;

    modport master (
        input  start, abort, state_changed,
        output re, drop, state_cheak, busy, done, converged, iter_count
    );

    modport slave (
        output start, abort, state_changed,
        input  re, drop, state_cheak, busy, done, converged, iter_count
    );
endinterface

// File: rtl/onn_phase_sequencer.sv
// Oscillatory-neural-network phase sequencer. It clears and loads the phase
// registers, then lets them oscillate for SETTLE_CYC cycles. It then pulses a
// state check and evaluates the returned change flags. This repeats until the
// network stops changing or MAX_ITER checks have been issued.
// Optional feature macro: ONN_STABLE2_EN. When it is defined, two consecutive
// all-quiet evaluations are needed before the run counts as converged.
module onn_phase_sequencer #(
    parameter int N_OSC      = 15,
    parameter int SETTLE_CYC = 16,
    parameter int MAX_ITER   = 32
) (
    input  logic                   clk,
    input  logic                   ren,
    onn_phase_sequencer_if.master  bus
);

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [7:0] MAX_LD    = 8'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, SETTLE, CHECK, EVAL, DONE
    } state_t;

    state_t           state;
    logic [7:0]       settle_cnt;
    logic [N_OSC-1:0] flags;
    logic             any_changed;
`ifdef ONN_STABLE2_EN
    logic             stable_seen;
`endif

    assign flags       = bus.state_changed;
    assign any_changed = |flags;

    // Sequencer FSM: every output is a register updated together with the state.
    // NOTE: all state and outputs use non-blocking assignments. Every register
    // then sees the pre-edge values, which keeps the update order from mattering.
    always_ff @(posedge clk or negedge ren) begin
        if (!ren) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            bus.re          <= 1'b0;
            bus.drop        <= 1'b0;
            bus.state_cheak <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.converged   <= 1'b0;
            bus.iter_count  <= '0;
`ifdef ONN_STABLE2_EN
            stable_seen     <= 1'b0;
`endif
        end else begin
            // Strobes default low, so each one lasts exactly one cycle.
            bus.re          <= 1'b0;
            bus.drop        <= 1'b0;
            bus.state_cheak <= 1'b0;
            bus.done        <= 1'b0;

            if (state != IDLE && bus.abort) begin
                // Cancel: drop back to IDLE without a done pulse.
                // The iteration count is kept for inspection.
                state         <= IDLE;
                settle_cnt    <= '0;
                bus.busy      <= 1'b0;
                bus.converged <= 1'b0;
`ifdef ONN_STABLE2_EN
                stable_seen   <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state          <= CLEAR;
                            bus.re         <= 1'b1;
                            bus.busy       <= 1'b1;
                            bus.iter_count <= '0;
                            bus.converged  <= 1'b0;
`ifdef ONN_STABLE2_EN
                            stable_seen    <= 1'b0;
`endif
                        end
                    end
                    CLEAR: begin
                        state    <= LOAD;
                        bus.drop <= 1'b1;
                    end
                    LOAD: begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LD;
                    end
                    SETTLE: begin
                        if (settle_cnt <= 8'd1) begin
                            state           <= CHECK;
                            settle_cnt      <= '0;
                            bus.state_cheak <= 1'b1;
                            bus.iter_count  <= bus.iter_count + 8'd1;
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    CHECK: begin
                        // The phase registers answer the check during EVAL.
                        state <= EVAL;
                    end
                    EVAL: begin
`ifdef ONN_STABLE2_EN
                        if (!any_changed && stable_seen) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.converged <= 1'b1;
                        end else if (bus.iter_count >= MAX_LD) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.converged <= 1'b0;
                        end else begin
                            state       <= SETTLE;
                            settle_cnt  <= SETTLE_LD;
                            stable_seen <= !any_changed;
                        end
`else
                        if (!any_changed) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.converged <= 1'b1;
                        end else if (bus.iter_count >= MAX_LD) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.converged <= 1'b0;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end
`endif
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onn_phase_sequencer.sv
// Self-checking bench for onn_phase_sequencer. It uses a table of run
// scenarios with a scoreboard of expected run results. Hand-written sequences
// cover abort, start while busy, reset mid-run and a short MAX_ITER instance.
module tb_onn_phase_sequencer;

    logic clk = 1'b0;
    logic ren = 1'b0;
    always #5 clk = ~clk;

    onn_phase_sequencer_if #(.N_OSC(15)) bus ();
    onn_phase_sequencer_if #(.N_OSC(15)) bus4 ();

    onn_phase_sequencer #(.N_OSC(15)) dut (
        .clk (clk),
        .ren (ren),
        .bus (bus)
    );

    onn_phase_sequencer #(.N_OSC(15), .SETTLE_CYC(1), .MAX_ITER(4)) dut4 (
        .clk (clk),
        .ren (ren),
        .bus (bus4)
    );

    typedef struct {
        string       name;
        int          n_dirty;   // number of leading checks answered with flags
        logic [14:0] flags;
        int          exp_done;  // cycle of done after the start-sampling edge
        int          exp_conv;
        int          exp_iter;
    } vec_t;

    vec_t vecs[4];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one scenario on the default instance.
    // The expected result is queued at start and popped when done appears.
    task automatic run_vec(input vec_t v);
        int   cyc, re_n, re_cyc, drop_cyc, chk_first, chk_n, done_cyc, overlap;
        vec_t e;
        re_n = 0; re_cyc = 0; drop_cyc = 0; chk_first = 0; chk_n = 0;
        done_cyc = 0; overlap = 0;
        sb.push_back(v);
        bus.state_changed = '0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 1;
        while (done_cyc == 0 && cyc < 2000) begin
            if (bus.re) begin re_n++; re_cyc = cyc; end
            if (bus.drop) drop_cyc = cyc;
            if (bus.state_cheak) begin
                chk_n++;
                if (chk_first == 0) chk_first = cyc;
                bus.state_changed = (chk_n <= v.n_dirty) ? v.flags : 15'h0000;
            end
            if (int'(bus.re) + int'(bus.drop) + int'(bus.state_cheak) + int'(bus.done) > 1)
                overlap++;
            if (bus.done) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        e = sb.pop_front();
        if (done_cyc == 0) $display("FAIL %s timeout: got no done expected done", e.name);
        check({e.name, " done_cycle"}, done_cyc, e.exp_done);
        check({e.name, " converged"}, bus.converged, e.exp_conv);
        check({e.name, " iter_count"}, bus.iter_count, e.exp_iter);
        check({e.name, " re_cycle"}, re_cyc, 1);
        check({e.name, " re_pulses"}, re_n, 1);
        check({e.name, " drop_cycle"}, drop_cyc, 2);
        check({e.name, " first_check"}, chk_first, 19);
        check({e.name, " check_pulses"}, chk_n, e.exp_iter);
        check({e.name, " strobe_overlap"}, overlap, 0);
        @(negedge clk);
        check({e.name, " done_one_cycle"}, bus.done, 0);
        check({e.name, " idle_busy"}, bus.busy, 0);
        check({e.name, " conv_hold"}, bus.converged, e.exp_conv);
        check({e.name, " iter_hold"}, bus.iter_count, e.exp_iter);
        bus.state_changed = '0;
    endtask

    initial begin
        int cyc, re_n, chk_n, chk_first, done_cyc, seen;

        vecs[0] = '{"max_iter", 255, 15'h7FFF, 21 + 31 * 18, 0, 32};
`ifdef ONN_STABLE2_EN
        vecs[1] = '{"quiet",   0, 15'h0004, 39, 1, 2};
        vecs[2] = '{"dirty2",  2, 15'h0004, 75, 1, 4};
        vecs[3] = '{"dirty1",  1, 15'h4000, 57, 1, 3};
`else
        vecs[1] = '{"quiet",   0, 15'h0004, 21, 1, 1};
        vecs[2] = '{"dirty2",  2, 15'h0004, 57, 1, 3};
        vecs[3] = '{"dirty1",  1, 15'h4000, 39, 1, 2};
`endif

        bus.start = 1'b0;  bus.abort = 1'b0;  bus.state_changed = '0;
        bus4.start = 1'b0; bus4.abort = 1'b0; bus4.state_changed = 15'h7FFF;

        // Outputs while held in reset.
        @(negedge clk);
        check("rst busy", bus.busy, 0);
        check("rst strobes", {bus.re, bus.drop, bus.state_cheak, bus.done}, 0);
        check("rst converged", bus.converged, 0);
        check("rst iter_count", bus.iter_count, 0);
        @(negedge clk); ren = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Abort in CHECK. A second start during the run must be ignored.
        bus.state_changed = 15'h0001;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 1; re_n = 0; seen = 0;
        while (seen == 0 && cyc < 200) begin
            if (bus.re) re_n++;
            bus.start = (cyc == 5);
            if (bus.state_cheak) seen = cyc;
            else begin @(negedge clk); cyc++; end
        end
        bus.start = 1'b0;
        check("abort check_cycle", seen, 19);
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort strobes", {bus.re, bus.drop, bus.state_cheak, bus.done}, 0);
        check("abort converged", bus.converged, 0);
        check("abort iter_count", bus.iter_count, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done || bus.busy || bus.re) seen++;
            @(negedge clk);
        end
        check("abort quiet_after", seen, 0);
        check("busy start ignored re_pulses", re_n, 1);

        // Abort and start together in IDLE: abort wins.
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
        check("idle abort_wins busy", bus.busy, 0);
        check("idle abort_wins re", bus.re, 0);
        check("idle abort_wins iter", bus.iter_count, 1);

        // Asynchronous reset in the second SETTLE of a run.
        bus.state_changed = 15'h0004;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int i = 1; i < 25; i++) @(negedge clk);
        check("pre_reset busy", bus.busy, 1);
        check("pre_reset iter", bus.iter_count, 1);
        #2 ren = 1'b0;
        #1;
        check("async_rst busy", bus.busy, 0);
        check("async_rst strobes", {bus.re, bus.drop, bus.state_cheak, bus.done}, 0);
        check("async_rst iter", bus.iter_count, 0);
        check("async_rst converged", bus.converged, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("in_reset no_done", seen, 0);
        ren = 1'b1;
        @(negedge clk);
        run_vec(vecs[1]);

        // Short instance: SETTLE_CYC=1 and MAX_ITER=4 with all flags stuck high.
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        cyc = 1; chk_n = 0; chk_first = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 200) begin
            if (bus4.state_cheak) begin
                chk_n++;
                if (chk_first == 0) chk_first = cyc;
            end
            if (bus4.done) done_cyc = cyc;
            else begin @(negedge clk); cyc++; end
        end
        check("m4 check_pulses", chk_n, 4);
        check("m4 first_check", chk_first, 4);
        check("m4 done_cycle", done_cyc, 15);
        check("m4 converged", bus4.converged, 0);
        check("m4 iter_count", bus4.iter_count, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
